// File: rtl/time_set_entry.sv
// time_set_entry
// Keypad time-entry stage that sits in front of the time-of-day counter.
// Decimal key presses shift into a four-digit HH:MM buffer. When the time
// button is pressed, the buffer is checked. A valid time produces a
// one-cycle load strobe. An invalid time produces a one-cycle error strobe
// and clears the buffer. An entry is dropped after TIMEOUT_SEC idle seconds.
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   one_second               one-cycle tick, once per second
//   key, key_valid           key code (0-9 digits, 10-15 ignored) and strobe
//   time_button              one-cycle commit request
//   new_current_time_*       buffered digits (ms_hr, ls_hr, ms_min, ls_min)
//   load_new_c               one-cycle strobe: counter loads the digits
//   entry_active             entry in progress (display shows the buffer)
//   digit_count              digits entered this entry, saturates at 4
//   entry_error              one-cycle strobe: commit rejected
module time_set_entry #(
  parameter int TIMEOUT_SEC = 10,
  parameter int TIMEOUT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       time_button,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       load_new_c,
  output logic       entry_active,
  output logic [2:0] digit_count,
  output logic       entry_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_SEC);
  localparam logic [TIMEOUT_W-1:0] TIMER_ONE     = TIMEOUT_W'(1);

  state_t               state_r, state_s;
  logic [3:0]           ms_hr_r, ls_hr_r, ms_min_r, ls_min_r;
  logic [3:0]           ms_hr_s, ls_hr_s, ms_min_s, ls_min_s;
  logic                 load_r, load_s;
  logic                 active_r, active_s;
  logic [2:0]           count_r, count_s;
  logic                 error_r, error_s;
  logic [TIMEOUT_W-1:0] timer_r, timer_s;
  logic                 accept_s;
  logic [2:0]           count_inc_s;

  // The time is valid up to 23:59. Missing leading digits count as zero.
  function automatic logic time_is_valid(input logic [3:0] mh,
                                         input logic [3:0] lh,
                                         input logic [3:0] mm);
    logic ok;
    ok = 1'b1;
    if (mh > 4'd2) begin
      ok = 1'b0;
    end else if ((mh == 4'd2) && (lh > 4'd3)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    if (mm > 4'd5) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  assign accept_s    = key_valid && (key <= 4'd9);
  assign count_inc_s = (count_r == 3'd4) ? 3'd4 : (count_r + 3'd1);

  // Next-state and next-output logic. Each output register is fed from here.
  always_comb begin
    state_s  = state_r;
    ms_hr_s  = ms_hr_r;
    ls_hr_s  = ls_hr_r;
    ms_min_s = ms_min_r;
    ls_min_s = ls_min_r;
    load_s   = 1'b0;
    active_s = active_r;
    count_s  = count_r;
    error_s  = 1'b0;
    timer_s  = timer_r;

    case (state_r)
      ST_IDLE: begin
        timer_s = '0;
        if (accept_s) begin
          // The buffer is already zero in IDLE, so the first digit lands
          // alone in the units-of-minutes position.
          state_s  = ST_ENTRY;
          ms_hr_s  = 4'd0;
          ls_hr_s  = 4'd0;
          ms_min_s = 4'd0;
          ls_min_s = key;
          count_s  = 3'd1;
          active_s = 1'b1;
        end else begin
          ms_hr_s  = 4'd0;
          ls_hr_s  = 4'd0;
          ms_min_s = 4'd0;
          ls_min_s = 4'd0;
          count_s  = 3'd0;
          active_s = 1'b0;
        end
      end

      ST_ENTRY: begin
        active_s = 1'b1;
        if (time_button) begin
          if (time_is_valid(ms_hr_r, ls_hr_r, ms_min_r)) begin
            state_s = ST_LOAD;
            load_s  = 1'b1;
          end else begin
            error_s  = 1'b1;
            ms_hr_s  = 4'd0;
            ls_hr_s  = 4'd0;
            ms_min_s = 4'd0;
            ls_min_s = 4'd0;
            count_s  = 3'd0;
            timer_s  = '0;
          end
        end else if (accept_s) begin
          ms_hr_s  = ls_hr_r;
          ls_hr_s  = ms_min_r;
          ms_min_s = ls_min_r;
          ls_min_s = key;
          count_s  = count_inc_s;
          timer_s  = '0;
        end else if (one_second) begin
          if ((timer_r + TIMER_ONE) == TIMEOUT_LIMIT) begin
            // The entry is abandoned silently. No load and no error are issued.
            state_s  = ST_IDLE;
            ms_hr_s  = 4'd0;
            ls_hr_s  = 4'd0;
            ms_min_s = 4'd0;
            ls_min_s = 4'd0;
            count_s  = 3'd0;
            active_s = 1'b0;
            timer_s  = '0;
          end else begin
            timer_s = timer_r + TIMER_ONE;
          end
        end else begin
          timer_s = timer_r;
        end
      end

      ST_LOAD: begin
        // The committed digits were shown for this single cycle.
        state_s  = ST_IDLE;
        ms_hr_s  = 4'd0;
        ls_hr_s  = 4'd0;
        ms_min_s = 4'd0;
        ls_min_s = 4'd0;
        count_s  = 3'd0;
        active_s = 1'b0;
        timer_s  = '0;
      end

      default: begin
        state_s  = ST_IDLE;
        ms_hr_s  = 4'd0;
        ls_hr_s  = 4'd0;
        ms_min_s = 4'd0;
        ls_min_s = 4'd0;
        count_s  = 3'd0;
        active_s = 1'b0;
        timer_s  = '0;
      end
    endcase
  end

  // State and output registers. Reset has priority over every input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      ms_hr_r  <= 4'd0;
      ls_hr_r  <= 4'd0;
      ms_min_r <= 4'd0;
      ls_min_r <= 4'd0;
      load_r   <= 1'b0;
      active_r <= 1'b0;
      count_r  <= 3'd0;
      error_r  <= 1'b0;
      timer_r  <= '0;
    end else begin
      state_r  <= state_s;
      ms_hr_r  <= ms_hr_s;
      ls_hr_r  <= ls_hr_s;
      ms_min_r <= ms_min_s;
      ls_min_r <= ls_min_s;
      load_r   <= load_s;
      active_r <= active_s;
      count_r  <= count_s;
      error_r  <= error_s;
      timer_r  <= timer_s;
    end
  end

  assign new_current_time_ms_hr  = ms_hr_r;
  assign new_current_time_ls_hr  = ls_hr_r;
  assign new_current_time_ms_min = ms_min_r;
  assign new_current_time_ls_min = ls_min_r;
  assign load_new_c              = load_r;
  assign entry_active            = active_r;
  assign digit_count             = count_r;
  assign entry_error             = error_r;

endmodule
